// File: rtl/rob.sv
// Reorder buffer: allocates indices at dispatch, collects out-of-order writebacks and retires in order.
// Writeback to head in cycle N -> commit_* in N+2; dis_ready drops while full or while flush pulses.
module rob #(
    parameter int ROB_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dis_valid,
    input  logic [4:0]               dis_rd_addr,
    input  logic                     dis_regf_we,
    output logic                     dis_ready,
    output logic [ROB_IDX_WIDTH-1:0] dis_rob_idx,
    input  logic                     wb_valid,
    input  logic [ROB_IDX_WIDTH-1:0] wb_rob_idx,
    input  logic [31:0]              wb_data,
    input  logic                     wb_mispredict,
    output logic                     commit_valid,
    output logic [ROB_IDX_WIDTH-1:0] commit_rob_idx,
    output logic                     commit_regf_we,
    output logic [4:0]               commit_rd_addr,
    output logic [31:0]              commit_data,
    output logic                     flush
);

    localparam int W     = ROB_IDX_WIDTH;
    localparam int DEPTH = 2 ** W;
    localparam logic [W:0] PTR_ONE = (W + 1)'(1);

    typedef struct packed {
        logic        vld;
        logic        done;
        logic        mispredict;
        logic        regf_we;
        logic [4:0]  rd_addr;
        logic [31:0] dat;
    } rob_entry_t;

    rob_entry_t ent_q [DEPTH];
    rob_entry_t ent_d [DEPTH];

    logic [W:0]   head_q, head_d;
    logic [W:0]   tail_q, tail_d;

    logic         commit_valid_q,   commit_valid_d;
    logic [W-1:0] commit_rob_idx_q, commit_rob_idx_d;
    logic         commit_regf_we_q, commit_regf_we_d;
    logic [4:0]   commit_rd_addr_q, commit_rd_addr_d;
    logic [31:0]  commit_data_q,    commit_data_d;
    logic         flush_q,          flush_d;

    logic [W-1:0] head_idx;
    logic [W-1:0] tail_idx;
    rob_entry_t   head_ent;
    logic         full;
    logic         alloc;
    logic         retire;

    assign head_idx = head_q[W-1:0];
    assign tail_idx = tail_q[W-1:0];
    assign head_ent = ent_q[head_idx];

    // Wrap bits differ but indices match: every slot is occupied.
    assign full   = (head_q[W] != tail_q[W]) && (head_idx == tail_idx);
    assign alloc  = dis_valid && dis_ready;
    // Retire looks only at registered state, so a same-cycle writeback to head waits a cycle.
    assign retire = head_ent.vld && head_ent.done;

    assign dis_ready      = !full && !flush_q;
    assign dis_rob_idx    = tail_idx;
    assign commit_valid   = commit_valid_q;
    assign commit_rob_idx = commit_rob_idx_q;
    assign commit_regf_we = commit_regf_we_q;
    assign commit_rd_addr = commit_rd_addr_q;
    assign commit_data    = commit_data_q;
    assign flush          = flush_q;

    always_comb begin
        ent_d            = ent_q;
        head_d           = head_q;
        tail_d           = tail_q;
        commit_valid_d   = 1'b0;
        commit_rob_idx_d = commit_rob_idx_q;
        commit_regf_we_d = commit_regf_we_q;
        commit_rd_addr_d = commit_rd_addr_q;
        commit_data_d    = commit_data_q;
        flush_d          = 1'b0;

        if (alloc) begin
            ent_d[tail_idx].vld        = 1'b1;
            ent_d[tail_idx].done       = 1'b0;
            ent_d[tail_idx].mispredict = 1'b0;
            ent_d[tail_idx].regf_we    = dis_regf_we;
            ent_d[tail_idx].rd_addr    = dis_rd_addr;
            ent_d[tail_idx].dat        = '0;
            tail_d                     = tail_q + PTR_ONE;
        end

        if (wb_valid && ent_q[wb_rob_idx].vld) begin
            ent_d[wb_rob_idx].done       = 1'b1;
            ent_d[wb_rob_idx].dat        = wb_data;
            ent_d[wb_rob_idx].mispredict = wb_mispredict;
        end

        if (retire) begin
            commit_valid_d       = 1'b1;
            commit_rob_idx_d     = head_idx;
            commit_regf_we_d     = head_ent.regf_we && (head_ent.rd_addr != 5'd0);
            commit_rd_addr_d     = head_ent.rd_addr;
            commit_data_d        = head_ent.dat;
            ent_d[head_idx].vld  = 1'b0;
            head_d               = head_q + PTR_ONE;

            // A mispredicted retire still commits itself, then squashes everything younger,
            // including any allocation attempted on this same edge.
            if (head_ent.mispredict) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_d[i].vld = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                flush_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q           <= '0;
            tail_q           <= '0;
            commit_valid_q   <= 1'b0;
            commit_rob_idx_q <= '0;
            commit_regf_we_q <= 1'b0;
            commit_rd_addr_q <= '0;
            commit_data_q    <= '0;
            flush_q          <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            head_q           <= head_d;
            tail_q           <= tail_d;
            commit_valid_q   <= commit_valid_d;
            commit_rob_idx_q <= commit_rob_idx_d;
            commit_regf_we_q <= commit_regf_we_d;
            commit_rd_addr_q <= commit_rd_addr_d;
            commit_data_q    <= commit_data_d;
            flush_q          <= flush_d;
        end
    end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for rob: a queue-based program-order model predicts every commit and the
// dispatch handshake; a monitor pops predictions whenever the DUT presents a commit.
module tb_rob;

    localparam int W     = 5;
    localparam int DEPTH = 32;

    logic         clk;
    logic         rst_n;
    logic         dis_valid;
    logic [4:0]   dis_rd_addr;
    logic         dis_regf_we;
    logic         dis_ready;
    logic [W-1:0] dis_rob_idx;
    logic         wb_valid;
    logic [W-1:0] wb_rob_idx;
    logic [31:0]  wb_data;
    logic         wb_mispredict;
    logic         commit_valid;
    logic [W-1:0] commit_rob_idx;
    logic         commit_regf_we;
    logic [4:0]   commit_rd_addr;
    logic [31:0]  commit_data;
    logic         flush;

    rob #(.ROB_IDX_WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dis_valid      (dis_valid),
        .dis_rd_addr    (dis_rd_addr),
        .dis_regf_we    (dis_regf_we),
        .dis_ready      (dis_ready),
        .dis_rob_idx    (dis_rob_idx),
        .wb_valid       (wb_valid),
        .wb_rob_idx     (wb_rob_idx),
        .wb_data        (wb_data),
        .wb_mispredict  (wb_mispredict),
        .commit_valid   (commit_valid),
        .commit_rob_idx (commit_rob_idx),
        .commit_regf_we (commit_regf_we),
        .commit_rd_addr (commit_rd_addr),
        .commit_data    (commit_data),
        .flush          (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          cyc;
        int          idx;
        logic [4:0]  rd;
        logic [31:0] dat;
        bit          we;
        bit          mp;
    } exp_t;

    exp_t        exp_q[$];
    int          ord_q[$];
    bit          m_vld  [DEPTH];
    bit          m_done [DEPTH];
    bit          m_mp   [DEPTH];
    bit          m_we   [DEPTH];
    logic [4:0]  m_rd   [DEPTH];
    logic [31:0] m_dat  [DEPTH];
    int          nxt;
    bit          m_flush;

    int n_cmp    = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int n_commit = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_ready();
        return (ord_q.size() < DEPTH) && !m_flush;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i]  = 1'b0;
            m_done[i] = 1'b0;
        end
        ord_q.delete();
        exp_q.delete();
        nxt     = 0;
        m_flush = 1'b0;
    endtask

    // One clock edge of program-order semantics, evaluated on pre-edge state.
    task automatic model_update(input bit dv, input logic [4:0] rd, input bit we,
                                input bit wv, input int widx, input logic [31:0] wdat,
                                input bit wmp);
        bit   rdy;
        bit   ret;
        int   h;
        exp_t e;
        rdy = model_ready();
        ret = 1'b0;
        h   = 0;
        if (ord_q.size() > 0 && m_done[ord_q[0]]) begin
            ret   = 1'b1;
            h     = ord_q[0];
            e.cyc = cyc;
            e.idx = h;
            e.rd  = m_rd[h];
            e.dat = m_dat[h];
            e.we  = m_we[h] && (m_rd[h] != 5'd0);
            e.mp  = m_mp[h];
            exp_q.push_back(e);
        end
        if (wv && m_vld[widx]) begin
            m_done[widx] = 1'b1;
            m_dat[widx]  = wdat;
            m_mp[widx]   = wmp;
        end
        if (ret) begin
            m_vld[h] = 1'b0;
            void'(ord_q.pop_front());
        end
        if (ret && e.mp) begin
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
            ord_q.delete();
            nxt     = 0;
            m_flush = 1'b1;
        end else begin
            m_flush = 1'b0;
            if (dv && rdy) begin
                m_vld[nxt]  = 1'b1;
                m_done[nxt] = 1'b0;
                m_mp[nxt]   = 1'b0;
                m_we[nxt]   = we;
                m_rd[nxt]   = rd;
                ord_q.push_back(nxt);
                nxt = (nxt + 1) % DEPTH;
            end
        end
    endtask

    // Called at a negedge: check handshake, drive one cycle of inputs, advance the model.
    task automatic step(input bit dv, input logic [4:0] rd, input bit we,
                        input bit wv, input int widx, input logic [31:0] wdat, input bit wmp);
        bit rdy_exp;
        rdy_exp = model_ready();
        chk("dis_ready", 32'(dis_ready), 32'(rdy_exp));
        if (rdy_exp) chk("dis_rob_idx", 32'(dis_rob_idx), 32'(nxt));
        dis_valid     = dv;
        dis_rd_addr   = rd;
        dis_regf_we   = we;
        wb_valid      = wv;
        wb_rob_idx    = W'(widx);
        wb_data       = wdat;
        wb_mispredict = wmp;
        @(posedge clk);
        cyc++;
        model_update(dv, rd, we, wv, widx, wdat, wmp);
        @(negedge clk);
        dis_valid = 1'b0;
        wb_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
    endtask

    task automatic disp(input logic [4:0] rd, input bit we);
        step(1'b1, rd, we, 1'b0, 0, 32'd0, 1'b0);
    endtask

    task automatic wb(input int idx, input logic [31:0] d, input bit mp);
        step(1'b0, 5'd0, 1'b0, 1'b1, idx, d, mp);
    endtask

    // Asynchronous reset placed between clock edges; outputs must clear with no edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst dis_ready", 32'(dis_ready), 32'd1);
        chk("rst dis_rob_idx", 32'(dis_rob_idx), 32'd0);
        chk("rst commit_valid", 32'(commit_valid), 32'd0);
        chk("rst flush", 32'(flush), 32'd0);
        chk("rst commit_data", commit_data, 32'd0);
        #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (ord_q.size() > 0 || exp_q.size() > 0); i++) begin
            int cand[$];
            foreach (ord_q[k]) if (!m_done[ord_q[k]]) cand.push_back(ord_q[k]);
            if (cand.size() > 0) wb(cand[0], $urandom, 1'b0);
            else idle(1);
        end
        chk("drain finished", 32'(ord_q.size() + exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (commit_valid) n_commit++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_valid", 32'(commit_valid), 32'd1);
                if (commit_valid) begin
                    chk("commit cycle", 32'(cyc), 32'(e.cyc));
                    chk("commit_rob_idx", 32'(commit_rob_idx), 32'(e.idx));
                    chk("commit_rd_addr", 32'(commit_rd_addr), 32'(e.rd));
                    chk("commit_data", commit_data, e.dat);
                    chk("commit_regf_we", 32'(commit_regf_we), 32'(e.we));
                    chk("flush", 32'(flush), 32'(e.mp));
                end
            end else begin
                chk("unexpected commit_valid", 32'(commit_valid), 32'd0);
                chk("flush without commit", 32'(flush), 32'd0);
            end
        end
    end

    initial begin
        int c0;
        rst_n         = 1'b1;
        dis_valid     = 1'b0;
        dis_rd_addr   = '0;
        dis_regf_we   = 1'b0;
        wb_valid      = 1'b0;
        wb_rob_idx    = '0;
        wb_data       = '0;
        wb_mispredict = 1'b0;
        model_reset();

        do_reset();

        // In-order commit of out-of-order writebacks.
        disp(5'd1, 1'b1);
        disp(5'd2, 1'b1);
        disp(5'd3, 1'b1);
        wb(2, 32'h33, 1'b0);
        wb(0, 32'h11, 1'b0);
        wb(1, 32'h22, 1'b0);
        idle(4);

        // Fill to full, ignored 33rd request, retire one, wrap to index 0.
        do_reset();
        for (int i = 0; i < DEPTH; i++) disp(5'(i), 1'b1);
        disp(5'd7, 1'b1);
        wb(0, 32'hA0, 1'b0);
        idle(1);
        disp(5'd9, 1'b1);
        disp(5'd10, 1'b1);
        drain();

        // Mispredict at index 1 squashes 2 and 3.
        do_reset();
        for (int i = 0; i < 4; i++) disp(5'(i + 4), 1'b1);
        wb(1, 32'hB1, 1'b1);
        wb(0, 32'hB0, 1'b0);
        wb(2, 32'hB2, 1'b0);
        wb(3, 32'hB3, 1'b0);
        for (int i = 0; i < 4; i++) disp(5'(i + 12), 1'b1);
        idle(2);
        drain();

        // Write to x0 commits but with regf_we suppressed.
        disp(5'd0, 1'b1);
        wb(nxt == 0 ? DEPTH - 1 : nxt - 1, 32'hDEAD, 1'b0);
        idle(3);

        // Randomized mix of dispatch, writeback and occasional mispredicts.
        for (int n = 0; n < 1500; n++) begin
            int          cand[$];
            bit          wv;
            int          widx;
            foreach (ord_q[k]) if (!m_done[ord_q[k]]) cand.push_back(ord_q[k]);
            wv   = 1'b0;
            widx = 0;
            if (cand.size() > 0 && $urandom_range(0, 99) < 55) begin
                wv   = 1'b1;
                widx = cand[$urandom_range(0, cand.size() - 1)];
            end else if ($urandom_range(0, 99) < 10) begin
                wv   = 1'b1;
                widx = $urandom_range(0, DEPTH - 1);
            end
            step($urandom_range(0, 99) < 65, 5'($urandom), 1'($urandom),
                 wv, widx, $urandom, $urandom_range(0, 99) < 3);
        end
        drain();

        // Reset with ten entries in flight and a commit on the outputs.
        do_reset();
        for (int i = 0; i < 10; i++) disp(5'(i + 1), 1'b1);
        wb(0, 32'hC0, 1'b0);
        idle(1);
        chk("pre-reset commit visible", 32'(commit_valid), 32'd1);
        do_reset();
        c0 = n_commit;
        wb(4, 32'hC4, 1'b0);
        idle(5);
        chk("no commit after reset", 32'(n_commit - c0), 32'd0);

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
